mips_datapath_alu_muldiv: RTL and testbench

Multi-cycle multiply/divide unit that owns the architectural HI/LO registers for the MIPS pipeline.
It sits beside the combinational ALU in the EX stage and accepts one operation per start pulse. It reports busy while working and pulses done when HI/LO commit.
It generalises the single-cycle multiply path with a parametrised width, a configurable multiply latency, an iterative signed/unsigned divider, and flush support.

---
 rtl/mips_datapath_alu_muldiv_pkg.sv | 35 +++
 rtl/mips_datapath_alu_divider_iter.sv | 88 ++++++++
 rtl/mips_datapath_alu_muldiv.sv | 223 ++++++++++++++++++++++
 tb/tb_mips_datapath_alu_muldiv.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_datapath_alu_muldiv_pkg.sv
// Shared types for the MIPS multiply/divide unit:
// op encodings, FSM states and a width helper.
package mips_datapath_alu_muldiv_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_MULS = 3'd1,
    OP_MULU = 3'd2,
    OP_DIVS = 3'd3,
    OP_DIVU = 3'd4,
    OP_MTHI = 3'd5,
    OP_MTLO = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // ceil(log2(n)); counters add one bit so they can hold n itself
  function automatic int clog2w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_datapath_alu_divider_iter.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle.
// The first step is taken on the load edge, so DATA_W edges finish it.
module mips_datapath_alu_divider_iter
  import mips_datapath_alu_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_last,
  output logic              o_done,
  output logic [DATA_W-1:0] o_quo,
  output logic [DATA_W-1:0] o_rem
);

  localparam int CW = clog2w(DATA_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvs;
  logic [CW-1:0]     r_cnt;
  logic              r_run;
  logic              r_done;

  logic [DATA_W-1:0] w_rem_in;
  logic [DATA_W-1:0] w_quo_in;
  logic [DATA_W-1:0] w_dvs_in;
  logic [DATA_W:0]   w_sh;
  logic [DATA_W-1:0] w_diff;
  logic              w_ge;
  logic [DATA_W-1:0] w_rem_nx;
  logic [DATA_W-1:0] w_quo_nx;

  // One shift-subtract step, fed from fresh operands on load
  always_comb begin
    w_rem_in = i_load ? '0 : r_rem;
    w_quo_in = i_load ? i_dividend : r_quo;
    w_dvs_in = i_load ? i_divisor : r_dvs;
    w_sh     = {w_rem_in, w_quo_in[DATA_W-1]};
    w_ge     = (w_sh >= {1'b0, w_dvs_in});
    w_diff   = w_sh[DATA_W-1:0] - w_dvs_in;
    w_rem_nx = w_ge ? w_diff : w_sh[DATA_W-1:0];
    w_quo_nx = {w_quo_in[DATA_W-2:0], w_ge};
  end

  // Iteration registers, step counter and completion flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else if (i_load) begin
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
        r_dvs <= w_dvs_in;
        r_cnt <= CW'(1);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == LAST) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_last = r_run && (r_cnt == LAST);
  assign o_done = r_done;
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;

endmodule

// File: rtl/mips_datapath_alu_muldiv.sv
// MIPS multiply/divide unit owning HI/LO: pipelined multiply,
// iterative signed/unsigned divide, MTHI/MTLO and flush.
module mips_datapath_alu_muldiv
  import mips_datapath_alu_muldiv_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int MCW = $clog2(MUL_CYCLES + 1);
  localparam logic [MCW-1:0] MUL_LAST =
    MCW'((MUL_CYCLES >= 2) ? (MUL_CYCLES - 2) : 0);
  localparam logic [DATA_W-1:0] MOST_NEG =
    {1'b1, {(DATA_W-1){1'b0}}};

  state_e r_state;
  state_e w_next;

  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_done;
  logic [2*DATA_W-1:0] r_prod;
  logic [MCW-1:0]      r_mcnt;
  logic                r_special;
  logic [DATA_W-1:0]   r_sp_hi;
  logic [DATA_W-1:0]   r_sp_lo;
  logic                r_neg_q;
  logic                r_neg_r;

  op_e                 w_op;
  logic                w_accept;
  logic                w_sdiv;
  logic [DATA_W-1:0]   w_mag1;
  logic [DATA_W-1:0]   w_mag2;
  logic                w_dz;
  logic                w_ovf;
  logic [2*DATA_W-1:0] w_ma;
  logic [2*DATA_W-1:0] w_mb;
  logic [2*DATA_W-1:0] w_prod;

  logic                w_div_load;
  logic                w_div_abort;
  logic                w_div_start;
  logic                w_mul_start;
  logic                w_mul_now;
  logic                w_mul_commit;
  logic                w_fix_commit;
  logic                w_mthi;
  logic                w_mtlo;

  logic                w_div_last;
  logic                w_div_done;
  logic [DATA_W-1:0]   w_div_quo;
  logic [DATA_W-1:0]   w_div_rem;
  logic [DATA_W-1:0]   w_q_fix;
  logic [DATA_W-1:0]   w_r_fix;

  // Operand decode: signs, magnitudes, special divides, product
  always_comb begin
    w_op     = op_e'(op);
    w_accept = start && !flush && (r_state == ST_IDLE);
    w_sdiv   = (w_op == OP_DIVS);
    w_mag1   = (w_sdiv && data1[DATA_W-1]) ? -data1 : data1;
    w_mag2   = (w_sdiv && data2[DATA_W-1]) ? -data2 : data2;
    w_dz     = (data2 == '0);
    w_ovf    = w_sdiv && (data1 == MOST_NEG) && (&data2);
    if (w_op == OP_MULS) begin
      w_ma = {{DATA_W{data1[DATA_W-1]}}, data1};
      w_mb = {{DATA_W{data2[DATA_W-1]}}, data2};
    end else begin
      w_ma = {{DATA_W{1'b0}}, data1};
      w_mb = {{DATA_W{1'b0}}, data2};
    end
    w_prod  = w_ma * w_mb;
    w_q_fix = r_neg_q ? -w_div_quo : w_div_quo;
    w_r_fix = r_neg_r ? -w_div_rem : w_div_rem;
  end

  // Next-state and commit strobes
  always_comb begin
    w_next       = r_state;
    w_div_load   = 1'b0;
    w_div_abort  = 1'b0;
    w_div_start  = 1'b0;
    w_mul_start  = 1'b0;
    w_mul_now    = 1'b0;
    w_mul_commit = 1'b0;
    w_fix_commit = 1'b0;
    w_mthi       = 1'b0;
    w_mtlo       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          unique case (w_op)
            OP_MULS, OP_MULU: begin
              w_mul_start = 1'b1;
              if (MUL_CYCLES == 1) w_mul_now = 1'b1;
              else w_next = ST_MUL;
            end
            OP_DIVS, OP_DIVU: begin
              w_div_start = 1'b1;
              if (w_dz || w_ovf) begin
                w_next = ST_FIX;
              end else begin
                w_next     = ST_DIV;
                w_div_load = 1'b1;
              end
            end
            OP_MTHI: w_mthi = 1'b1;
            OP_MTLO: w_mtlo = 1'b1;
            OP_NOP, OP_RSVD: ;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (r_mcnt == MUL_LAST) begin
          w_mul_commit = 1'b1;
          w_next       = ST_IDLE;
        end else if (flush) begin
          w_next = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (flush) begin
          w_div_abort = 1'b1;
          w_next      = ST_IDLE;
        end else if (w_div_last) begin
          w_next = ST_FIX;
        end
      end
      ST_FIX: begin
        w_fix_commit = r_special || w_div_done;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Operand latch, multiply hold, special results and HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_prod    <= '0;
      r_mcnt    <= '0;
      r_special <= 1'b0;
      r_sp_hi   <= '0;
      r_sp_lo   <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      r_done <= w_mul_now || w_mul_commit || w_fix_commit;
      if (w_mul_start) begin
        r_prod <= w_prod;
        r_mcnt <= '0;
      end else if (r_state == ST_MUL) begin
        r_mcnt <= r_mcnt + MCW'(1);
      end
      if (w_div_start) begin
        r_special <= w_dz || w_ovf;
        r_sp_hi   <= w_dz ? data1 : '0;
        r_sp_lo   <= w_dz ? '1 : MOST_NEG;
        r_neg_q   <= w_sdiv && (data1[DATA_W-1] ^ data2[DATA_W-1]);
        r_neg_r   <= w_sdiv && data1[DATA_W-1];
      end
      if (w_mthi) r_hi <= data1;
      if (w_mtlo) r_lo <= data1;
      if (w_mul_now) begin
        r_hi <= w_prod[2*DATA_W-1:DATA_W];
        r_lo <= w_prod[DATA_W-1:0];
      end
      if (w_mul_commit) begin
        r_hi <= r_prod[2*DATA_W-1:DATA_W];
        r_lo <= r_prod[DATA_W-1:0];
      end
      if (w_fix_commit) begin
        r_hi <= r_special ? r_sp_hi : w_r_fix;
        r_lo <= r_special ? r_sp_lo : w_q_fix;
      end
    end
  end

  mips_datapath_alu_divider_iter #(
    .DATA_W(DATA_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_div_load),
    .i_abort   (w_div_abort),
    .i_dividend(w_mag1),
    .i_divisor (w_mag2),
    .o_last    (w_div_last),
    .o_done    (w_div_done),
    .o_quo     (w_div_quo),
    .o_rem     (w_div_rem)
  );

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mips_datapath_alu_muldiv.sv
// Bench for mips_datapath_alu_muldiv: arithmetic reference model
// with per-cycle compare, plus directed literal checks.
module tb_mips_datapath_alu_muldiv;
  import mips_datapath_alu_muldiv_pkg::*;

  localparam int W  = 32;
  localparam int MC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] data1;
  logic [W-1:0] data2;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_datapath_alu_muldiv #(
    .DATA_W(W),
    .MUL_CYCLES(MC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .data1(data1),
    .data2(data2),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  // Reference: {hi, lo} result of an op from plain arithmetic
  function automatic logic [2*W-1:0] ref_result(
    input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sp;
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    logic signed [W-1:0]   da;
    logic signed [W-1:0]   db;
    logic signed [W-1:0]   q;
    logic signed [W-1:0]   r;
    logic [2*W-1:0]        res;
    res = '0;
    da  = a;
    db  = b;
    if (o == OP_MULS) begin
      sa  = 64'(da);
      sb  = 64'(db);
      sp  = sa * sb;
      res = sp;
    end else if (o == OP_MULU) begin
      res = {32'h0, a} * {32'h0, b};
    end else if (b == 0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (o == OP_DIVS && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = {32'h0, 32'h8000_0000};
    end else if (o == OP_DIVS) begin
      q   = da / db;
      r   = da % db;
      res = {r, q};
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  // Reference: busy cycles between accept and commit
  function automatic int ref_lat(
    input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    if (o == OP_MULS || o == OP_MULU) return MC - 1;
    if (b == 0) return 1;
    if (o == OP_DIVS && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W;
  endfunction

  logic         m_busy;
  logic         m_done;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;
  logic [2*W-1:0] m_res;
  int           m_left;

  // Behavioural model: pending result with a countdown to commit
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_res  <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_hi   <= m_res[2*W-1:W];
          m_lo   <= m_res[W-1:0];
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end else if (flush) begin
          m_busy <= 1'b0;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start && !flush) begin
        if (op >= 3'd1 && op <= 3'd4) begin
          m_res  <= ref_result(op, data1, data2);
          m_left <= ref_lat(op, data1, data2);
          m_busy <= 1'b1;
        end else if (op == OP_MTHI) begin
          m_hi <= data1;
        end else if (op == OP_MTLO) begin
          m_lo <= data1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare DUT to model on every falling edge outside reset
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk1("cyc_busy", busy, m_busy);
        chk1("cyc_done", done, m_done);
        chk("cyc_hi", hi, m_hi);
        chk("cyc_lo", lo, m_lo);
      end
    end
  endtask

  // Issue one op, wait for done, check latency and HI/LO literals.
  // hold keeps start high one extra cycle with altered operands.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit hold,
                        input int exp_lat, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input string name);
    int lat;
    lat   = -1;
    op    = o;
    data1 = a;
    data2 = b;
    start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        data1 = ~a;
        data2 = ~b;
        if (!hold) start = 1'b0;
      end
      if (n == 2) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    chki({name, "_lat"}, lat, exp_lat);
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_lo"}, lo, elo);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    data1 = '0;
    data2 = '0;
    fork
      compare_loop();
    join_none
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);

    run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2,
           32'hFFFF_FFFE, 32'h0000_0001, "mulu_max");
    run_op(OP_MULS, 32'hFFFF_FFFD, 32'd7, 1'b1, 2,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, "muls_neg");
    repeat (3) @(posedge clk);
    #1;
    chk("muls_once_hi", hi, 32'hFFFF_FFFF);
    chk("muls_once_lo", lo, 32'hFFFF_FFEB);

    run_op(OP_DIVS, 32'hFFFF_FFF9, 32'd2, 1'b0, 33,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, "divs_m7_2");
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 33,
           32'd2, 32'd14, "divu_100_7");
    run_op(OP_DIVS, 32'd7, 32'hFFFF_FFFE, 1'b0, 33,
           32'd1, 32'hFFFF_FFFD, "divs_7_m2");
    run_op(OP_DIVS, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b0, 33,
           32'hFFFF_FFFE, 32'd2, "divs_m8_m3");
    run_op(OP_DIVU, 32'h8000_0000, 32'd3, 1'b0, 33,
           32'd2, 32'h2AAA_AAAA, "divu_big");
    run_op(OP_DIVU, 32'h1234, 32'h0, 1'b0, 2,
           32'h1234, 32'hFFFF_FFFF, "div_zero");
    run_op(OP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 2,
           32'h0, 32'h8000_0000, "divs_ovf");

    // start with flush in IDLE is dropped
    op    = OP_MTLO;
    data1 = 32'h1111;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_lo", lo, 32'h8000_0000);

    // MTHI then DIVS flushed mid-iteration
    op    = OP_MTHI;
    data1 = 32'hA5A5_A5A5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    chk1("mthi_done", done, 1'b0);
    op    = OP_DIVS;
    data1 = 32'hFFFF_FFEC;
    data2 = 32'd3;
    start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk1("flush_busy", busy, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk1("flush_no_done", done, 1'b0);
    end
    chk("flush_hi", hi, 32'hA5A5_A5A5);
    chk("flush_lo", lo, 32'h8000_0000);

    // flush in the multiply commit cycle still commits
    op    = OP_MULU;
    data1 = 32'd6;
    data2 = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk1("flush_commit_done", done, 1'b1);
    chk("flush_commit_lo", lo, 32'd42);
    chk("flush_commit_hi", hi, 32'd0);

    // asynchronous reset mid-divide
    op    = OP_DIVU;
    data1 = 32'd1000;
    data2 = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    op    = OP_MTLO;
    data1 = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'd5);
    chk1("mtlo_done", done, 1'b0);
    chk1("mtlo_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk1("mtlo_no_done", done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
